// File: rtl/bcd_updown_counter_pkg.sv
// bcd_pkg: shared BCD digit type, digit limits and load-value clamp.
package bcd_pkg;
    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX  = 4'd9;
    localparam bcd_t BCD_ZERO = 4'd0;
    function automatic bcd_t clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction
endpackage

// File: rtl/bcd_updown_counter_if.sv
// bcd_updown_counter_if: front-panel control inputs and BCD count outputs.
interface bcd_updown_counter_if #(parameter int DIGITS = 3) ();
    logic                  step_n;
    logic                  en;
    logic                  up;
    logic                  load_n;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic                  tc;
    modport master (output step_n, en, up, load_n, load_val, input bcd, tc);
    modport slave  (input step_n, en, up, load_n, load_val, output bcd, tc);
endinterface

// File: rtl/bcd_updown_counter_digit_cell.sv
// bcd_digit_cell: one registered BCD digit with load, carry and borrow.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic ld,
    input  bcd_t ld_val,
    output bcd_t q,
    output logic co,
    output logic bo
);
    bcd_t r_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   r_q <= BCD_ZERO;
        else if (ld)  r_q <= clamp(ld_val);
        else if (inc) r_q <= (r_q == BCD_MAX)  ? BCD_ZERO : r_q + 4'd1;
        else if (dec) r_q <= (r_q == BCD_ZERO) ? BCD_MAX  : r_q - 4'd1;
    end
    assign q  = r_q;
    assign co = (r_q == BCD_MAX) & inc;
    assign bo = (r_q == BCD_ZERO) & dec;
endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter with pushbutton
// synchroniser, parallel load, wrap/saturate limits and terminal-count pulse.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter bit SATURATE = 1'b0
) (
    input logic clk,
    input logic rst_n,
    bcd_updown_counter_if.slave bus
);
    logic r_s1, r_s2, r_s3, r_tc;
    logic w_step, w_evt, w_sat, w_ld;
    logic [DIGITS:0]   w_inc, w_dec;
    logic [DIGITS-1:0] w_is9, w_is0;
    bcd_t              w_q [DIGITS];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_s3, r_s2, r_s1} <= 3'b111;
            r_tc               <= 1'b0;
        end else begin
            {r_s3, r_s2, r_s1} <= {r_s2, r_s1, bus.step_n};
            r_tc               <= w_inc[DIGITS] | w_dec[DIGITS] | w_sat;
        end
    end
    assign w_step = r_s3 & ~r_s2;
    assign w_ld   = ~bus.load_n;
    assign w_evt  = w_step & bus.en & bus.load_n;
    // At a limit in saturate mode the step is swallowed but still flagged on tc.
    assign w_sat    = SATURATE && w_evt && (bus.up ? &w_is9 : &w_is0);
    assign w_inc[0] = w_evt & bus.up & ~w_sat;
    assign w_dec[0] = w_evt & ~bus.up & ~w_sat;
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_cell u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc    (w_inc[i]),
            .dec    (w_dec[i]),
            .ld     (w_ld),
            .ld_val (bus.load_val[4*i+:4]),
            .q      (w_q[i]),
            .co     (w_inc[i+1]),
            .bo     (w_dec[i+1])
        );
        assign w_is9[i]           = (w_q[i] == BCD_MAX);
        assign w_is0[i]           = (w_q[i] == BCD_ZERO);
        assign bus.bcd[4*i+:4]    = w_q[i];
    end
    assign bus.tc = r_tc;
endmodule
